// File: rtl/fir_iq_decim.sv
// Dual-channel (I/Q) direct-form FIR with a double-buffered coefficient bank,
// runtime decimation, round-half-up narrowing with saturation and a sticky flag.
module fir_iq_decim #(
    parameter int NB_INPUT   = 8,
    parameter int NBF_INPUT  = 7,
    parameter int NB_COEFF   = 16,
    parameter int NBF_COEFF  = 15,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 7,
    parameter int N_COEFFS   = 17,
    parameter int MAX_DECIM  = 8,
    localparam int NB_ADDR   = $clog2(N_COEFFS),
    localparam int NB_DEC    = $clog2(MAX_DECIM) + 1,
    localparam int NB_FULL   = NB_INPUT + NB_COEFF + $clog2(N_COEFFS),
    localparam int NBF_FULL  = NBF_INPUT + NBF_COEFF
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_valid,
    input  logic [NB_INPUT-1:0] i_symb_I,
    input  logic [NB_INPUT-1:0] i_symb_Q,
    input  logic                i_coeff_we,
    input  logic [NB_ADDR-1:0]  i_coeff_addr,
    input  logic [NB_COEFF-1:0] i_coeff_data,
    input  logic [NB_DEC-1:0]   i_decim,
    input  logic                i_commit,
    output logic                o_valid,
    output logic [NB_FULL-1:0]  o_fir_full_symbI,
    output logic [NB_FULL-1:0]  o_fir_full_symbQ,
    output logic [NB_OUTPUT-1:0] o_fir_symbI,
    output logic [NB_OUTPUT-1:0] o_fir_symbQ,
    output logic                o_sat
);
    localparam int NB_PROD = NB_INPUT + NB_COEFF;
    localparam int NB_DROP = NBF_FULL - NBF_OUTPUT;
    localparam int NB_RND  = NB_FULL - NB_DROP;
    localparam logic [NB_FULL-1:0] RND_ADD = NB_FULL'(1) << (NB_DROP - 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_meta_q, rst_sync_q, rst_n;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n = rst_sync_q;

    logic signed [NB_INPUT-1:0] xi_q [N_COEFFS];
    logic signed [NB_INPUT-1:0] xi_d [N_COEFFS];
    logic signed [NB_INPUT-1:0] xq_q [N_COEFFS];
    logic signed [NB_INPUT-1:0] xq_d [N_COEFFS];
    logic signed [NB_COEFF-1:0] shadow_q [N_COEFFS];
    logic signed [NB_COEFF-1:0] shadow_d [N_COEFFS];
    logic signed [NB_COEFF-1:0] active_q [N_COEFFS];
    logic signed [NB_COEFF-1:0] active_d [N_COEFFS];
    logic [NB_DEC-1:0]   dec_q, dec_d, phase_q, phase_d, dec_clamped, cur_phase, cur_dec;
    logic signed [NB_FULL-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d, sum_i, sum_q;
    logic                emit_q, emit_d;
    logic                valid_q, valid_d, sat_q, sat_d;
    logic [NB_FULL-1:0]  full_i_q, full_i_d, full_q_q, full_q_d;
    logic [NB_OUTPUT-1:0] nar_i_q, nar_i_d, nar_q_q, nar_q_d;
    logic                sat_i, sat_qc;

    // Returns {saturated, value} after round-half-up and clamping.
    function automatic logic [NB_OUTPUT:0] sat_round(input logic [NB_FULL-1:0] acc);
        logic [NB_FULL-1:0]       r;
        logic [NB_RND-1:0]        t;
        logic [NB_RND-NB_OUTPUT:0] top;
        r   = acc + RND_ADD;
        t   = NB_RND'($signed(r) >>> NB_DROP);
        top = t[NB_RND-1:NB_OUTPUT-1];
        if ((&top) || (~|top))
            sat_round = {1'b0, t[NB_OUTPUT-1:0]};
        else if (t[NB_RND-1])
            sat_round = {1'b1, 1'b1, {(NB_OUTPUT-1){1'b0}}};
        else
            sat_round = {1'b1, 1'b0, {(NB_OUTPUT-1){1'b1}}};
    endfunction

    always_comb begin
        if (i_decim == '0)
            dec_clamped = NB_DEC'(1);
        else if (i_decim > NB_DEC'(MAX_DECIM))
            dec_clamped = NB_DEC'(MAX_DECIM);
        else
            dec_clamped = i_decim;
    end

    // Input stage: bank/phase bookkeeping, delay-line shift and MAC over the
    // pre-commit active bank, so a sample arriving with a commit uses old taps.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        dec_d     = dec_q;
        phase_d   = phase_q;
        xi_d      = xi_q;
        xq_d      = xq_q;
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        emit_d    = 1'b0;
        cur_phase = phase_q;
        cur_dec   = dec_q;
        sum_i     = '0;
        sum_q     = '0;
        if (i_coeff_we && ({1'b0, i_coeff_addr} < (NB_ADDR + 1)'(N_COEFFS)))
            shadow_d[i_coeff_addr] = i_coeff_data;
        if (i_commit) begin
            active_d  = shadow_d;
            dec_d     = dec_clamped;
            phase_d   = '0;
            cur_phase = '0;
            cur_dec   = dec_clamped;
        end
        if (i_valid) begin
            xi_d[0] = i_symb_I;
            xq_d[0] = i_symb_Q;
            for (int k = 1; k < N_COEFFS; k++) begin
                xi_d[k] = xi_q[k-1];
                xq_d[k] = xq_q[k-1];
            end
            for (int k = 0; k < N_COEFFS; k++) begin
                sum_i = sum_i + NB_FULL'(NB_PROD'(xi_d[k]) * NB_PROD'(active_q[k]));
                sum_q = sum_q + NB_FULL'(NB_PROD'(xq_d[k]) * NB_PROD'(active_q[k]));
            end
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            emit_d  = (cur_phase == '0);
            phase_d = (cur_phase == cur_dec - 1'b1) ? '0 : cur_phase + 1'b1;
        end
    end

    always_comb begin
        valid_d  = emit_q;
        full_i_d = full_i_q;
        full_q_d = full_q_q;
        nar_i_d  = nar_i_q;
        nar_q_d  = nar_q_q;
        sat_d    = sat_q;
        {sat_i, nar_i_d} = emit_q ? sat_round(acc_i_q) : {1'b0, nar_i_q};
        {sat_qc, nar_q_d} = emit_q ? sat_round(acc_q_q) : {1'b0, nar_q_q};
        if (emit_q) begin
            full_i_d = acc_i_q;
            full_q_d = acc_q_q;
            sat_d    = sat_q | sat_i | sat_qc;
        end
    end

    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_COEFFS; k++) begin
                xi_q[k]     <= '0;
                xq_q[k]     <= '0;
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            dec_q    <= NB_DEC'(1);
            phase_q  <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            emit_q   <= 1'b0;
            valid_q  <= 1'b0;
            full_i_q <= '0;
            full_q_q <= '0;
            nar_i_q  <= '0;
            nar_q_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            xi_q     <= xi_d;
            xq_q     <= xq_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            dec_q    <= dec_d;
            phase_q  <= phase_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            emit_q   <= emit_d;
            valid_q  <= valid_d;
            full_i_q <= full_i_d;
            full_q_q <= full_q_d;
            nar_i_q  <= nar_i_d;
            nar_q_q  <= nar_q_d;
            sat_q    <= sat_d;
        end
    end

    assign o_valid          = valid_q;
    assign o_fir_full_symbI = full_i_q;
    assign o_fir_full_symbQ = full_q_q;
    assign o_fir_symbI      = nar_i_q;
    assign o_fir_symbQ      = nar_q_q;
    assign o_sat            = sat_q;

endmodule
